// File: rtl/capture_sequencer_if.sv
// Bundles the capture-engine strobes, host readout handshake and BRAM port
// of the capture sequencer.
interface capture_sequencer_if #(
   parameter int ADDR_W = 18,
   parameter int DATA_W = 8
);
   logic              cap_run;
   logic              cap_en;
   logic              cap_we;
   logic [ADDR_W-1:0] cap_addr;
   logic [DATA_W-1:0] cap_data;

   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;

   logic              bram_en;
   logic              bram_we;
   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_wdata;
   logic [DATA_W-1:0] bram_rdata;

   // Sequencer side.
   modport slave (
      output cap_run,
      input  cap_en, cap_we, cap_addr, cap_data,
      input  rd_req, rd_addr,
      output rd_data, rd_valid,
      output bram_en, bram_we, bram_addr, bram_wdata,
      input  bram_rdata
   );

   // Engine / host / BRAM side.
   modport master (
      input  cap_run,
      output cap_en, cap_we, cap_addr, cap_data,
      output rd_req, rd_addr,
      input  rd_data, rd_valid,
      input  bram_en, bram_we, bram_addr, bram_wdata,
      output bram_rdata
   );
endinterface

// File: rtl/capture_sequencer.sv
// Arm/trigger/limit sequencing for the logic capture path, plus arbitration
// of the single-port capture BRAM between engine writes and host reads.
module capture_sequencer #(
   parameter int ADDR_W = 18,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       control,
   input  logic [31:0]       config0,
   input  logic [31:0]       config1,
   output logic [31:0]       status,
   input  logic [DATA_W-1:0] datain,
   capture_sequencer_if.slave bus
);
   localparam int CW = ADDR_W + 1;

   typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

   state_t          state_q, state_d;
   logic            arm_prev_q;
   logic            arm_evt, abort, trig, wr, cnt_inc, limit_hit;
   logic [CW-1:0]   count_q, count_d, count_inc, eff_limit;
   logic [19:0]     lim_raw;
   logic            done_q, done_d, full_q, full_d;
   logic            armed_q, capturing_q;
   logic            rd_grant;
   logic [2:1]      vld_pipe;
   logic [DATA_W-1:0] rd_data_q;
   logic [18:0]     count_ext;
   logic            unused_bits;

   assign unused_bits = ^{control[31:2], config0[31:16], config1[31:19]};

   assign arm_evt = control[0] & ~arm_prev_q;
   assign abort   = control[1];
   assign trig    = ((datain ^ config0[8 +: DATA_W]) & config0[DATA_W-1:0]) == '0;
   assign wr      = bus.cap_en & bus.cap_we;

   // A limit of 0 or anything beyond the BRAM depth means "fill the BRAM".
   assign lim_raw   = {1'b0, config1[18:0]};
   assign eff_limit = (lim_raw == 20'd0 || lim_raw > 20'(DEPTH)) ? CW'(DEPTH) : CW'(lim_raw);

   assign cnt_inc   = (state_q == CAPTURE) && wr;
   assign count_inc = count_q + 1'b1;
   // >= rather than == so a limit lowered mid-capture still stops the engine.
   assign limit_hit = cnt_inc && (count_inc >= eff_limit);

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      done_d  = done_q;
      full_d  = full_q;
      // A CAPTURE-state write is counted even when abort wins that cycle.
      if (cnt_inc)
         count_d = count_inc;
      case (state_q)
         IDLE, DONE: begin
            if (arm_evt) begin
               state_d = ARMED;
               count_d = '0;
               done_d  = 1'b0;
               full_d  = 1'b0;
            end
         end
         ARMED: begin
            if (abort)
               state_d = IDLE;
            else if (trig)
               state_d = CAPTURE;
         end
         CAPTURE: begin
            if (abort) begin
               state_d = IDLE;
            end else if (limit_hit) begin
               state_d = DONE;
               done_d  = 1'b1;
               full_d  = (eff_limit == CW'(DEPTH));
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         arm_prev_q  <= 1'b0;
         count_q     <= '0;
         done_q      <= 1'b0;
         full_q      <= 1'b0;
         armed_q     <= 1'b0;
         capturing_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         arm_prev_q  <= control[0];
         count_q     <= count_d;
         done_q      <= done_d;
         full_q      <= full_d;
         armed_q     <= (state_d == ARMED);
         capturing_q <= (state_d == CAPTURE);
      end
   end

   // Writes always own the port; a read waits for a write-free cycle and
   // stays single-outstanding until its rd_valid cycle has passed.
   assign rd_grant = ~reset & ~wr & bus.rd_req & ~(|vld_pipe);

   always_comb begin
      bus.bram_en    = 1'b0;
      bus.bram_we    = 1'b0;
      bus.bram_addr  = '0;
      bus.bram_wdata = '0;
      if (!reset) begin
         if (wr) begin
            bus.bram_en    = 1'b1;
            bus.bram_we    = 1'b1;
            bus.bram_addr  = bus.cap_addr;
            bus.bram_wdata = bus.cap_data;
         end else if (rd_grant) begin
            bus.bram_en   = 1'b1;
            bus.bram_addr = bus.rd_addr;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_pipe  <= '0;
         rd_data_q <= '0;
      end else begin
         vld_pipe <= {vld_pipe[1], rd_grant};
         if (vld_pipe[1])
            rd_data_q <= bus.bram_rdata;
      end
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = vld_pipe[2];
   assign bus.cap_run  = capturing_q;

   assign count_ext = 19'(count_q);
   assign status    = {count_ext, 8'd0, |vld_pipe, full_q, done_q, capturing_q, armed_q};
endmodule
